mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 22 ++
 rtl/mult_div_unit.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the E-stage and the multiply/divide unit.
// The E-stage drives the master side; the unit drives Busy and HI/LO.
interface mult_div_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cancel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, Op, A, B, Cancel,
    input  Busy, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, Cancel,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// MIPS-style HI/LO multiply/divide unit. The result is computed at launch and
// held back until a fixed latency elapses, modelling a multi-cycle datapath.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic             clk,
  input logic             rst_n,
  mult_div_unit_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   resHi_q, resHi_d;
  logic [31:0]   resLo_q, resLo_d;

  logic [63:0]   prodS, prodU;
  logic [31:0]   absA, absB, divisorS, divisorU;
  logic [31:0]   magQ, magR, quotS, remS, quotU, remU;

  // Signed division works on magnitudes so the 0x80000000 / -1 corner folds out naturally.
  always_comb begin
    prodS    = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
    prodU    = {32'd0, md.A} * {32'd0, md.B};
    absA     = md.A[31] ? (32'd0 - md.A) : md.A;
    absB     = md.B[31] ? (32'd0 - md.B) : md.B;
    divisorS = (absB == 32'd0) ? 32'd1 : absB;
    divisorU = (md.B == 32'd0) ? 32'd1 : md.B;
    magQ     = absA / divisorS;
    magR     = absA % divisorS;
    quotS    = (md.A[31] ^ md.B[31]) ? (32'd0 - magQ) : magQ;
    remS     = md.A[31] ? (32'd0 - magR) : magR;
    quotU    = md.A / divisorU;
    remU     = md.A % divisorU;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    resHi_d = resHi_q;
    resLo_d = resLo_q;

    case (state_q)
      IDLE: begin
        if (md.Start && !md.Cancel) begin
          case (md.Op)
            OP_MULT: begin
              resHi_d = prodS[63:32];
              resLo_d = prodS[31:0];
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_MULTU: begin
              resHi_d = prodU[63:32];
              resLo_d = prodU[31:0];
              cnt_d   = CW'(MULT_CYCLES);
              state_d = RUN;
            end
            // Divide-by-zero still occupies the unit but writes back the current HI/LO.
            OP_DIV: begin
              resHi_d = (md.B == 32'd0) ? hi_q : remS;
              resLo_d = (md.B == 32'd0) ? lo_q : quotS;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_DIVU: begin
              resHi_d = (md.B == 32'd0) ? hi_q : remU;
              resLo_d = (md.B == 32'd0) ? lo_q : quotU;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = md.A;
            OP_MTLO: lo_d = md.A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          hi_d    = resHi_q;
          lo_d    = resLo_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      resHi_q <= '0;
      resLo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      resHi_q <= resHi_d;
      resLo_q <= resLo_d;
    end
  end

  assign md.Busy = busy_q;
  assign md.HI   = hi_q;
  assign md.LO   = lo_q;

endmodule
